// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generator for the five-stage MIPS
// pipeline. Decodes the instruction in D and tracks destination register,
// result source and Tnew of every in-flight producer through E, M and W.
// Optional macro HAZARD_D_FORWARD_EN enables forwarding into the D-stage
// branch comparator; without it, D selects are 0 and Tuse=0 readers wait
// until their producer reaches W.

package hazard_ctrl_pkg;
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_MEM  = 2'd2;
  localparam logic [1:0] SRC_PC8  = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [1:0] src;
  } stage_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction
endpackage

// One source operand (rs or rt): its stall vote and its D/E forward selects.
module hazard_ctrl_lane
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_d,
  input  logic [1:0] tuse_d,
  input  logic [4:0] src_e,
  input  logic [4:0] e_a3,
  input  logic [1:0] e_tnew,
  input  stage_t     m_st,
  input  stage_t     w_st,
  output logic       stall,
  output logic [2:0] d_sel,
  output logic [2:0] e_sel
);
  logic hit_e, hit_m;

  // src_d is already zeroed for unused operands, so $0 / unused never hits
  assign hit_e = (src_d != 5'd0) && (src_d == e_a3);
  assign hit_m = (src_d != 5'd0) && (src_d == m_st.a3);

`ifdef HAZARD_D_FORWARD_EN
  assign stall = (hit_e && (tuse_d < e_tnew)) ||
                 (hit_m && (tuse_d < m_st.tnew));

  // D compare operand: jal in E gives PC8E, a finished producer in M gives AO/PC8
  always_comb begin
    d_sel = 3'd0;
    if (hit_e && e_tnew == 2'd0)
      d_sel = 3'd1;
    else if (hit_m && m_st.tnew == 2'd0)
      d_sel = (m_st.src == SRC_PC8) ? 3'd3 : 3'd2;
  end
`else
  // no D forwarding: a Tuse=0 reader waits for the producer to leave M
  assign stall = (hit_e && ((tuse_d < e_tnew) || (tuse_d == 2'd0))) ||
                 (hit_m && ((tuse_d < m_st.tnew) || (tuse_d == 2'd0)));
  assign d_sel = 3'd0;
`endif

  // E operand: M (finished) has priority over W; W forwards any completed result
  always_comb begin
    e_sel = 3'd0;
    if (src_e != 5'd0 && src_e == m_st.a3 && m_st.tnew == 2'd0)
      e_sel = (m_st.src == SRC_PC8) ? 3'd2 : 3'd1;
    else if (src_e != 5'd0 && src_e == w_st.a3 && w_st.tnew == 2'd0 &&
             w_st.src != SRC_NONE)
      e_sel = 3'd3;
  end
endmodule

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRD,
  output logic        Stall,
  output logic [2:0]  Forward_RS_D_Sel,
  output logic [2:0]  Forward_RT_D_Sel,
  output logic [2:0]  Forward_RS_E_Sel,
  output logic [2:0]  Forward_RT_E_Sel
);
  localparam int NUM_SRC = 2;  // lane 0 = rs, lane 1 = rt

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, shamt;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic       is_beq, is_jal;

  stage_t                      dec_st;
  logic [NUM_SRC-1:0][4:0]     src_d;
  logic [NUM_SRC-1:0][1:0]     tuse_d;

  stage_t                      e_q, m_q, w_q;
  logic [NUM_SRC-1:0][4:0]     src_e_q;

  logic [NUM_SRC-1:0]          lane_stall;
  logic [NUM_SRC-1:0][2:0]     d_sel, e_sel;

  assign op    = IRD[31:26];
  assign rs    = IRD[25:21];
  assign rt    = IRD[20:16];
  assign rd    = IRD[15:11];
  assign shamt = IRD[10:6];
  assign fn    = IRD[5:0];

  assign is_r    = (op == 6'h00) && (shamt == 5'd0);
  assign is_addu = is_r && (fn == 6'h21);
  assign is_subu = is_r && (fn == 6'h23);
  assign is_jr   = is_r && (fn == 6'h08);
  assign is_ori  = (op == 6'h0d);
  assign is_lui  = (op == 6'h0f);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2b);
  assign is_beq  = (op == 6'h04);
  assign is_jal  = (op == 6'h03);

  // decode IRD: destination/Tnew/source, plus used operands and their Tuse
  always_comb begin
    dec_st = '0;
    src_d  = '0;
    tuse_d = '0;
    if (is_addu || is_subu) begin
      dec_st    = '{a3: rd, tnew: 2'd1, src: SRC_ALU};
      src_d[0]  = rs;
      src_d[1]  = rt;
      tuse_d[0] = 2'd1;
      tuse_d[1] = 2'd1;
    end else if (is_jr) begin
      src_d[0]  = rs;
      tuse_d[0] = 2'd0;
    end else if (is_ori) begin
      dec_st    = '{a3: rt, tnew: 2'd1, src: SRC_ALU};
      src_d[0]  = rs;
      tuse_d[0] = 2'd1;
    end else if (is_lui) begin
      dec_st    = '{a3: rt, tnew: 2'd1, src: SRC_ALU};
    end else if (is_lw) begin
      dec_st    = '{a3: rt, tnew: 2'd2, src: SRC_MEM};
      src_d[0]  = rs;
      tuse_d[0] = 2'd1;
    end else if (is_sw) begin
      src_d[0]  = rs;
      src_d[1]  = rt;
      tuse_d[0] = 2'd1;
      tuse_d[1] = 2'd2;
    end else if (is_beq) begin
      src_d[0]  = rs;
      src_d[1]  = rt;
    end else if (is_jal) begin
      dec_st    = '{a3: 5'd31, tnew: 2'd0, src: SRC_PC8};
    end
  end

  // advance tracking state; a stall injects a bubble into E
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      src_e_q <= '0;
    end else begin
      if (Stall) begin
        e_q     <= '0;
        src_e_q <= '0;
      end else begin
        e_q     <= dec_st;
        src_e_q <= src_d;
      end
      m_q <= '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew), src: e_q.src};
      w_q <= '{a3: m_q.a3, tnew: tnew_dec(m_q.tnew), src: m_q.src};
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    hazard_ctrl_lane u_lane (
      .src_d  (src_d[i]),
      .tuse_d (tuse_d[i]),
      .src_e  (src_e_q[i]),
      .e_a3   (e_q.a3),
      .e_tnew (e_q.tnew),
      .m_st   (m_q),
      .w_st   (w_q),
      .stall  (lane_stall[i]),
      .d_sel  (d_sel[i]),
      .e_sel  (e_sel[i])
    );
  end

  assign Stall            = |lane_stall;
  assign Forward_RS_D_Sel = d_sel[0];
  assign Forward_RT_D_Sel = d_sel[1];
  assign Forward_RS_E_Sel = e_sel[0];
  assign Forward_RT_E_Sel = e_sel[1];
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Each cycle the expected
// {Stall, D selects, E selects} is queued as the instruction is driven into D
// and popped/compared at the following falling edge.
module tb_hazard_ctrl;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IRD = 32'h0;
  logic        Stall;
  logic [2:0]  Forward_RS_D_Sel, Forward_RT_D_Sel;
  logic [2:0]  Forward_RS_E_Sel, Forward_RT_E_Sel;

  hazard_ctrl dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .IRD              (IRD),
    .Stall            (Stall),
    .Forward_RS_D_Sel (Forward_RS_D_Sel),
    .Forward_RT_D_Sel (Forward_RT_D_Sel),
    .Forward_RS_E_Sel (Forward_RS_E_Sel),
    .Forward_RT_E_Sel (Forward_RT_E_Sel)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       stall;
    logic [2:0] rsd, rtd, rse, rte;
  } obs_t;

  typedef struct packed {
    logic [31:0] ir;
    obs_t        e;
  } step_t;

`ifdef HAZARD_D_FORWARD_EN
  localparam logic [2:0] D1 = 3'd1;
  localparam logic [2:0] D2 = 3'd2;
`else
  localparam logic [2:0] D1 = 3'd0;
  localparam logic [2:0] D2 = 3'd0;
`endif

  localparam logic [31:0] NOP = 32'h0;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  obs_t dut_obs;

  assign dut_obs = {Stall, Forward_RS_D_Sel, Forward_RT_D_Sel,
                    Forward_RS_E_Sel, Forward_RT_E_Sel};

  function automatic obs_t mk(input logic st, input logic [2:0] rsd,
                              input logic [2:0] rtd, input logic [2:0] rse,
                              input logic [2:0] rte);
    return {st, rsd, rtd, rse, rte};
  endfunction

  function automatic logic [31:0] i_addu(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'h23, rs, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'h2b, rs, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] i_ori(input logic [4:0] rt, input logic [4:0] rs);
    return {6'h0d, rs, rt, 16'h0001};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h04, rs, rt, 16'h0003};
  endfunction
  function automatic logic [31:0] i_jal();
    return {6'h03, 26'h0000040};
  endfunction

  // put an instruction into D just after the rising edge and queue its expectation
  task automatic drive(input logic [31:0] ir, input obs_t e);
    @(posedge Clk);
    #1;
    IRD = ir;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    repeat (3) begin
      @(posedge Clk);
      #1;
      IRD = NOP;
    end
  endtask

  task automatic test_reset();
    obs_t ex;
    Reset = 1'b1;
    IRD   = i_beq(5'd1, 5'd2);
    exp_q.push_back('0);
    @(negedge Clk);
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL reset_hold actual=%b expected=%b", dut_obs, ex);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.push_back('0);
    @(negedge Clk);
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL reset_release actual=%b expected=%b", dut_obs, ex);
    end
    drive(i_beq(5'd1, 5'd2), '0);
    @(negedge Clk);
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL reset_first_cycle actual=%b expected=%b", dut_obs, ex);
    end
  endtask

  task automatic test_alu_fwd();
    step_t s[$];
    obs_t  ex;
    flush();
    s.push_back({i_addu(5'd3, 5'd1, 5'd2), mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_addu(5'd4, 5'd3, 5'd3), mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd1, 3'd1)});
    s.push_back({i_addu(5'd3, 5'd1, 5'd2), mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_addu(5'd4, 5'd3, 5'd3), mk(1'b0, D2,   D2,   3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd3, 3'd3)});
    foreach (s[i]) begin
      drive(s[i].ir, s[i].e);
      @(negedge Clk);
      ex = exp_q.pop_front();
      checks++;
      if (dut_obs !== ex) begin
        failures++;
        $display("FAIL alu_fwd[%0d] actual=%b expected=%b", i, dut_obs, ex);
      end
    end
  endtask

  task automatic test_lw_stall();
    step_t s[$];
    obs_t  ex;
    flush();
    s.push_back({i_lw(5'd5, 5'd0),          mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_addu(5'd6, 5'd5, 5'd0),  mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_addu(5'd6, 5'd5, 5'd0),  mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                       mk(1'b0, 3'd0, 3'd0, 3'd3, 3'd0)});
    // store data has Tuse 2: no stall behind lw, nothing to forward in E yet
    s.push_back({i_lw(5'd10, 5'd0),         mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_sw(5'd10, 5'd0),         mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                       mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    foreach (s[i]) begin
      drive(s[i].ir, s[i].e);
      @(negedge Clk);
      ex = exp_q.pop_front();
      checks++;
      if (dut_obs !== ex) begin
        failures++;
        $display("FAIL lw_stall[%0d] actual=%b expected=%b", i, dut_obs, ex);
      end
    end
  endtask

  task automatic test_jal_fwd();
    step_t s[$];
    obs_t  ex;
    flush();
    s.push_back({i_jal(),                    mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_addu(5'd7, 5'd31, 5'd0),  mk(1'b0, D1,   3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                        mk(1'b0, 3'd0, 3'd0, 3'd2, 3'd0)});
    s.push_back({NOP,                        mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    foreach (s[i]) begin
      drive(s[i].ir, s[i].e);
      @(negedge Clk);
      ex = exp_q.pop_front();
      checks++;
      if (dut_obs !== ex) begin
        failures++;
        $display("FAIL jal_fwd[%0d] actual=%b expected=%b", i, dut_obs, ex);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    obs_t  ex;
    flush();
    s.push_back({i_ori(5'd8, 5'd0),        mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_beq(5'd8, 5'd0),        mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd0)});
`ifdef HAZARD_D_FORWARD_EN
    s.push_back({i_beq(5'd8, 5'd0),        mk(1'b0, 3'd2, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd3, 3'd0)});
`else
    s.push_back({i_beq(5'd8, 5'd0),        mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_beq(5'd8, 5'd0),        mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
`endif
    // lw feeding beq: two stall cycles in either build
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_lw(5'd9, 5'd0),         mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_beq(5'd9, 5'd9),        mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_beq(5'd9, 5'd9),        mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_beq(5'd9, 5'd9),        mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    foreach (s[i]) begin
      drive(s[i].ir, s[i].e);
      @(negedge Clk);
      ex = exp_q.pop_front();
      checks++;
      if (dut_obs !== ex) begin
        failures++;
        $display("FAIL branch[%0d] actual=%b expected=%b", i, dut_obs, ex);
      end
    end
  endtask

  task automatic test_zero_reg();
    step_t s[$];
    obs_t  ex;
    flush();
    s.push_back({i_addu(5'd0, 5'd1, 5'd2), mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_addu(5'd9, 5'd0, 5'd0), mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({NOP,                      mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_lw(5'd0, 5'd0),         mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    s.push_back({i_beq(5'd0, 5'd0),        mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0)});
    foreach (s[i]) begin
      drive(s[i].ir, s[i].e);
      @(negedge Clk);
      ex = exp_q.pop_front();
      checks++;
      if (dut_obs !== ex) begin
        failures++;
        $display("FAIL zero_reg[%0d] actual=%b expected=%b", i, dut_obs, ex);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t ex;
    flush();
    drive(i_lw(5'd5, 5'd0), '0);
    @(negedge Clk);
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL mid_reset_lw actual=%b expected=%b", dut_obs, ex);
    end
    drive(i_addu(5'd6, 5'd5, 5'd0), mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd0));
    @(negedge Clk);
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL mid_reset_stall actual=%b expected=%b", dut_obs, ex);
    end
    // assert reset between edges: stall must drop without a clock
    #2;
    Reset = 1'b1;
    exp_q.push_back('0);
    #1;
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL mid_reset_async actual=%b expected=%b", dut_obs, ex);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.push_back('0);
    @(negedge Clk);
    ex = exp_q.pop_front();
    checks++;
    if (dut_obs !== ex) begin
      failures++;
      $display("FAIL mid_reset_held_ird actual=%b expected=%b", dut_obs, ex);
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_lw_stall();
    test_jal_fwd();
    test_branch();
    test_zero_reg();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage MIPS pipeline; it is the producer side of the forwarding selects consumed by the E stage (`Forward_RS_E_Sel`, `Forward_RT_E_Sel`) and by the D-stage branch comparator. It decodes the instruction entering D and keeps its own pipelined copy of each in-flight instruction's destination register, result source and Tnew through E, M and W. From that copy it asserts `Stall` (freeze F/D, bubble into E) and drives every forwarding mux select.

## Interface
- No parameters.
- `Clk`  in  1  pipeline clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all tracking state.
- `IRD`  in  32  instruction currently in the D stage.
- `Stall`  out  1  1 = hold PC/IRD and load a bubble into E.
- `Forward_RS_D_Sel`, `Forward_RT_D_Sel`  out  3 each  D-stage compare operand: 0 = RF read, 1 = PC8E, 2 = AO, 3 = PC8fromM.
- `Forward_RS_E_Sel`, `Forward_RT_E_Sel`  out  3 each  E-stage operand: 0 = RSE/RTE, 1 = AO, 2 = PC8fromM, 3 = MUX_RF_WD_OUT.

## Operation
- Decoded set: addu (funct 0x21), subu (0x23), jr (0x08), ori (op 0x0d), lui (0x0f), lw (0x23), sw (0x2b), beq (0x04), j (0x02), jal (0x03). Any other encoding, including nop, is treated as having no sources and A3 = 0.
- A3: R-type uses rd; ori, lui and lw use rt; jal uses 31; all others use 0.
- Tuse: beq rs/rt = 0; jr rs = 0; addu/subu rs/rt = 1; ori/lw/sw rs = 1; sw rt = 2.
- Tnew at E entry: addu, subu, ori, lui = 1 (source ALU); lw = 2 (source MEM); jal = 0 (source PC8).
- Tracking registers per stage E/M/W: A3 (5 b), Tnew (2 b), src (2 b), plus rs/rt of E (5 b each).
- Per clock: E ← decode(IRD), or a bubble (A3 = 0, Tnew = 0) when `Stall`=1. M ← E and W ← M, with Tnew decremented and saturating at 0.
- Stall is combinational. It is asserted if, for stage X ∈ {E, M}, a used source s of IRD has s ≠ 0, s == A3_X and Tuse_s < Tnew_X.
- E select, evaluated for rs_E and rt_E independently. If M matches (A3_M ≠ 0 and Tnew_M == 0), select 2 when src_M = PC8, otherwise 1. Else, if W matches, select 3. Else select 0. M has priority over W.
- D select: match in E with Tnew_E == 0 (jal) → 1. Otherwise match in M with Tnew_M == 0 → 3 when src = PC8, otherwise 2. Otherwise 0. W is not covered because the register file is write-first.
- Register 0 never matches in any stage.

## Timing
- Reset: all tracking registers are 0, so `Stall` = 0 and all selects = 0 for any `IRD`, both during reset and in the first cycle after it.
- A dependent instruction directly behind lw stalls exactly 1 cycle (2 cycles for a beq source); an ALU producer feeding beq stalls 1 cycle.
- Stall and a new `IRD` are never simultaneous: while stalled, `IRD` is held, the bubble advances, and Stall is re-evaluated the next cycle.
- Reset asserted mid-stall clears E/M/W immediately; the held `IRD` is re-evaluated against empty state.
- Outputs are purely combinational from `IRD` and the registered state; forwarding adds zero-cycle latency.

## Configuration
- `HAZARD_D_FORWARD_EN` defined: D-stage forwarding as described above.
- Not defined: both D selects are tied to 0. Any Tuse = 0 source that matches a nonzero A3 in E or M stalls regardless of Tnew, waiting until the producer reaches W. E-stage logic is unchanged.

## Test plan
- Reset held with IRD = beq $1,$2 → Stall = 0 and all selects 0; after release, with no prior producers, still 0.
- addu $3,$1,$2 then addu $4,$3,$3 → no stall; next cycle Forward_RS_E_Sel = Forward_RT_E_Sel = 1. One intervening nop → both = 3.
- lw $5,0($0) then addu $6,$5,$0 → Stall = 1 for exactly 1 cycle; after the bubble, Forward_RS_E_Sel = 3.
- jal then addu $7,$31,$0 in D at the next edge → no stall; Forward_RS_E_Sel = 2 once the jal reaches M.
- ori $8,$0,1 then beq $8,$0 → Stall 1 cycle, then Forward_RS_D_Sel = 2. Without `HAZARD_D_FORWARD_EN`: Stall 2 cycles, D selects 0.
- addu $0,$1,$2 then addu $9,$0,$0 → Stall = 0 and all selects 0. Reset asserted mid-lw-stall → Stall drops to 0 asynchronously.
